// File: rtl/fft_dif_bf_stream.sv
// Streaming radix-2 DIF butterfly stage: A = a+b, B = (a-b)*W, 3-cycle pipeline with valid/ready.
// Build option FFT_BF_SAT_EN: clamp B components to DW+1 bits and flag ovf_o (default: wrap).
module fft_dif_bf_stream #(
    parameter int DW    = 25,
    parameter int TW    = 18,
    parameter int N     = 8,
    parameter int STAGE = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                in_first_i,
    input  logic [2*DW-1:0]     in_a_i,
    input  logic [2*DW-1:0]     in_b_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                out_first_o,
    output logic [2*(DW+1)-1:0] out_a_o,
    output logic [2*(DW+1)-1:0] out_b_o,
    output logic                frame_err_o,
    output logic                ovf_o
);
    localparam int  KW = (N > 2) ? $clog2(N / 2) : 1;
    localparam int  PW = DW + TW + 1;
    localparam int  QW = PW + 1;
    localparam int  RW = QW - (TW - 2);
    localparam int  TM = N >> (STAGE + 1);
    localparam real PI = 3.14159265358979323846;
    localparam logic signed [QW-1:0] RND = QW'(longint'(1) << (TW - 3));

    if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_n
        $error("fft_dif_bf_stream: N=%0d must be a power of two >= 2", N);
    end
    if ((STAGE < 0) || (STAGE >= $clog2(N))) begin : g_bad_stage
        $error("fft_dif_bf_stream: STAGE=%0d out of range for N=%0d", STAGE, N);
    end

    // Round-to-nearest (ties away from zero) into signed Q2.(TW-2).
    function automatic logic signed [TW-1:0] tw_round(input real v);
        real    s;
        integer q;
        s = v * (2.0 ** (TW - 2));
        if (s >= 0.0) q = $rtoi(s + 0.5);
        else          q = -$rtoi(0.5 - s);
        return TW'(q);
    endfunction

    logic signed [TW-1:0] rom_re [N/2];
    logic signed [TW-1:0] rom_im [N/2];

    genvar gi;
    for (gi = 0; gi < N / 2; gi++) begin : g_rom
        localparam logic signed [TW-1:0] WR = tw_round($cos(2.0 * PI * gi / N));
        localparam logic signed [TW-1:0] WI = tw_round(-$sin(2.0 * PI * gi / N));
        assign rom_re[gi] = WR;
        assign rom_im[gi] = WI;
    end

    logic                 en;
    logic                 hs;
    logic [KW-1:0]        k_reg;
    logic [KW-1:0]        k_use;
    logic [KW-1:0]        k_next;
    logic [KW-1:0]        m_idx;
    logic signed [DW-1:0] a_re, a_im, b_re, b_im;

    assign en          = out_ready_i | ~out_valid_o;
    assign in_ready_o  = en & rst_ni;
    assign hs          = in_valid_i & in_ready_o;
    assign a_re        = in_a_i[2*DW-1:DW];
    assign a_im        = in_a_i[DW-1:0];
    assign b_re        = in_b_i[2*DW-1:DW];
    assign b_im        = in_b_i[DW-1:0];

    // A frame start restarts the twiddle sequence at k=0 regardless of alignment.
    assign k_use       = in_first_i ? '0 : k_reg;
    assign k_next      = (k_use == KW'(N / 2 - 1)) ? '0 : k_use + 1'b1;
    assign m_idx       = KW'((k_use & KW'(TM - 1)) << STAGE);
    assign frame_err_o = hs & in_first_i & (k_reg != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            k_reg <= '0;
        else if (hs)
            k_reg <= k_next;
    end

    logic                 s1_valid_reg, s1_first_reg;
    logic signed [DW:0]   s1_sum_re_reg, s1_sum_im_reg, s1_diff_re_reg, s1_diff_im_reg;
    logic signed [TW-1:0] s1_w_re_reg, s1_w_im_reg;
    logic                 s2_valid_reg, s2_first_reg;
    logic signed [DW:0]   s2_sum_re_reg, s2_sum_im_reg;
    logic signed [PW-1:0] s2_rr_reg, s2_ii_reg, s2_ri_reg, s2_ir_reg;
    logic                 out_valid_reg, out_first_reg, ovf_reg;
    logic [2*DW+1:0]      out_a_reg, out_b_reg;

    logic signed [QW-1:0] p_re, p_im;
    logic [DW:0]          b_re_red, b_im_red;
    logic                 ovf_beat;

    assign p_re = QW'(s2_rr_reg) - QW'(s2_ii_reg);
    assign p_im = QW'(s2_ri_reg) + QW'(s2_ir_reg);

`ifdef FFT_BF_SAT_EN
    localparam logic signed [RW-1:0] B_MAX = RW'((longint'(1) << DW) - 1);
    localparam logic signed [RW-1:0] B_MIN = RW'(-(longint'(1) << DW));
    logic signed [RW-1:0] r_re, r_im;
    logic                 ovf_re, ovf_im;

    assign r_re     = RW'((p_re + RND) >>> (TW - 2));
    assign r_im     = RW'((p_im + RND) >>> (TW - 2));
    assign ovf_re   = (r_re > B_MAX) || (r_re < B_MIN);
    assign ovf_im   = (r_im > B_MAX) || (r_im < B_MIN);
    assign b_re_red = (r_re > B_MAX) ? B_MAX[DW:0] : ((r_re < B_MIN) ? B_MIN[DW:0] : r_re[DW:0]);
    assign b_im_red = (r_im > B_MAX) ? B_MAX[DW:0] : ((r_im < B_MIN) ? B_MIN[DW:0] : r_im[DW:0]);
    assign ovf_beat = ovf_re | ovf_im;
`else
    // Wrap: keep only the low DW+1 bits of the rounded result.
    assign b_re_red = (DW+1)'((p_re + RND) >>> (TW - 2));
    assign b_im_red = (DW+1)'((p_im + RND) >>> (TW - 2));
    assign ovf_beat = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_reg   <= 1'b0;
            s1_first_reg   <= 1'b0;
            s1_sum_re_reg  <= '0;
            s1_sum_im_reg  <= '0;
            s1_diff_re_reg <= '0;
            s1_diff_im_reg <= '0;
            s1_w_re_reg    <= '0;
            s1_w_im_reg    <= '0;
            s2_valid_reg   <= 1'b0;
            s2_first_reg   <= 1'b0;
            s2_sum_re_reg  <= '0;
            s2_sum_im_reg  <= '0;
            s2_rr_reg      <= '0;
            s2_ii_reg      <= '0;
            s2_ri_reg      <= '0;
            s2_ir_reg      <= '0;
            out_valid_reg  <= 1'b0;
            out_first_reg  <= 1'b0;
            out_a_reg      <= '0;
            out_b_reg      <= '0;
            ovf_reg        <= 1'b0;
        end else if (en) begin
            s1_valid_reg   <= hs;
            s1_first_reg   <= in_first_i;
            s1_sum_re_reg  <= (DW+1)'(a_re) + (DW+1)'(b_re);
            s1_sum_im_reg  <= (DW+1)'(a_im) + (DW+1)'(b_im);
            s1_diff_re_reg <= (DW+1)'(a_re) - (DW+1)'(b_re);
            s1_diff_im_reg <= (DW+1)'(a_im) - (DW+1)'(b_im);
            s1_w_re_reg    <= rom_re[m_idx];
            s1_w_im_reg    <= rom_im[m_idx];

            s2_valid_reg   <= s1_valid_reg;
            s2_first_reg   <= s1_first_reg;
            s2_sum_re_reg  <= s1_sum_re_reg;
            s2_sum_im_reg  <= s1_sum_im_reg;
            s2_rr_reg      <= PW'(s1_diff_re_reg) * PW'(s1_w_re_reg);
            s2_ii_reg      <= PW'(s1_diff_im_reg) * PW'(s1_w_im_reg);
            s2_ri_reg      <= PW'(s1_diff_re_reg) * PW'(s1_w_im_reg);
            s2_ir_reg      <= PW'(s1_diff_im_reg) * PW'(s1_w_re_reg);

            out_valid_reg  <= s2_valid_reg;
            out_first_reg  <= s2_first_reg;
            out_a_reg      <= {s2_sum_re_reg, s2_sum_im_reg};
            out_b_reg      <= {b_re_red, b_im_red};
            ovf_reg        <= ovf_beat;
        end
    end

    assign out_valid_o = out_valid_reg;
    assign out_first_o = out_first_reg;
    assign out_a_o     = out_a_reg;
    assign out_b_o     = out_b_reg;
    assign ovf_o       = ovf_reg;

endmodule

// File: tb/tb_fft_dif_bf_stream.sv
// Randomised and directed bench for fft_dif_bf_stream (STAGE=0 and STAGE=1 instances in lockstep),
// checked against a complex-arithmetic reference model with a per-instance scoreboard.
module tb_fft_dif_bf_stream;
    localparam int DW = 25;
    localparam int TW = 18;
    localparam int N  = 8;
    localparam int OW = DW + 1;

    typedef struct {
        longint a_re, a_im, b_re, b_im;
        bit     first;
        bit     ovf;
        int     t_in;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_first, out_ready;
    logic [2*DW-1:0] in_a, in_b;
    logic            in_ready0, out_valid0, out_first0, frame_err0, ovf0;
    logic            in_ready1, out_valid1, out_first1, frame_err1, ovf1;
    logic [2*OW-1:0] out_a0, out_b0, out_a1, out_b1;

    always #5 clk = ~clk;

    fft_dif_bf_stream #(.DW(DW), .TW(TW), .N(N), .STAGE(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready0),
        .in_first_i(in_first), .in_a_i(in_a), .in_b_i(in_b), .out_valid_o(out_valid0),
        .out_ready_i(out_ready), .out_first_o(out_first0), .out_a_o(out_a0), .out_b_o(out_b0),
        .frame_err_o(frame_err0), .ovf_o(ovf0)
    );

    fft_dif_bf_stream #(.DW(DW), .TW(TW), .N(N), .STAGE(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready1),
        .in_first_i(in_first), .in_a_i(in_a), .in_b_i(in_b), .out_valid_o(out_valid1),
        .out_ready_i(out_ready), .out_first_o(out_first1), .out_a_o(out_a1), .out_b_o(out_b1),
        .frame_err_o(frame_err1), .ovf_o(ovf1)
    );

    int     n_vec = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     k_model = 0;
    bit     chk_lat = 1'b1;
    bit     stalled_prev = 1'b0;
    logic [2*OW-1:0] held_a, held_b;
    logic   held_first, held_ovf;
    beat_t  exp_q0[$];
    beat_t  exp_q1[$];
    longint log_are0[$], log_bre0[$], log_bim0[$], log_ovf0[$], log_bre1[$], log_bim1[$];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic longint sx(input logic [63:0] v, input int w);
        longint r;
        r = longint'(v) & ((longint'(1) << w) - 1);
        if (r >= (longint'(1) << (w - 1))) r -= (longint'(1) << w);
        return r;
    endfunction

    function automatic longint tw_q(input real v);
        real s;
        s = v * (2.0 ** (TW - 2));
        if (s >= 0.0) return longint'($rtoi(s + 0.5));
        return -longint'($rtoi(0.5 - s));
    endfunction

    // Reference: B = (a-b) * exp(-j*2*pi*m/N), rounded then saturated or wrapped.
    function automatic beat_t model(input int stage, input longint are, input longint aim,
                                    input longint bre, input longint bim, input int k, input bit first);
        beat_t  e;
        int     m;
        real    ang;
        longint wr, wi, dr, di, pr, pim, lim;
        m     = (k % (N >> (stage + 1))) * (1 << stage);
        ang   = 2.0 * 3.14159265358979323846 * m / N;
        wr    = tw_q($cos(ang));
        wi    = tw_q(-$sin(ang));
        dr    = are - bre;
        di    = aim - bim;
        pr    = ((dr * wr - di * wi) + (longint'(1) << (TW - 3))) >>> (TW - 2);
        pim   = ((dr * wi + di * wr) + (longint'(1) << (TW - 3))) >>> (TW - 2);
        lim   = longint'(1) << DW;
        e.ovf = 1'b0;
`ifdef FFT_BF_SAT_EN
        if (pr > lim - 1) begin pr = lim - 1; e.ovf = 1'b1; end
        else if (pr < -lim) begin pr = -lim; e.ovf = 1'b1; end
        if (pim > lim - 1) begin pim = lim - 1; e.ovf = 1'b1; end
        else if (pim < -lim) begin pim = -lim; e.ovf = 1'b1; end
`else
        pr  = sx(pr, OW);
        pim = sx(pim, OW);
`endif
        e.a_re  = are + bre;
        e.a_im  = aim + bim;
        e.b_re  = pr;
        e.b_im  = pim;
        e.first = first;
        e.t_in  = cyc;
        return e;
    endfunction

    task automatic drive(input bit v, input bit f, input longint are, input longint aim,
                         input longint bre, input longint bim);
        in_valid = v;
        in_first = f;
        in_a     = {DW'(are), DW'(aim)};
        in_b     = {DW'(bre), DW'(bim)};
    endtask

    task automatic check_out(input int id, input logic of, input logic [2*OW-1:0] oa,
                             input logic [2*OW-1:0] ob, input logic ov);
        beat_t e;
        if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
            check($sformatf("spurious_out%0d", id), 1, 0);
            return;
        end
        e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("a_re%0d", id), sx(oa[2*OW-1:OW], OW), e.a_re);
        check($sformatf("a_im%0d", id), sx(oa[OW-1:0], OW), e.a_im);
        check($sformatf("b_re%0d", id), sx(ob[2*OW-1:OW], OW), e.b_re);
        check($sformatf("b_im%0d", id), sx(ob[OW-1:0], OW), e.b_im);
        check($sformatf("first%0d", id), of, e.first);
        check($sformatf("ovf%0d", id), ov, e.ovf);
        if (chk_lat) check($sformatf("latency%0d", id), cyc - e.t_in, 3);
        if (id == 0) begin
            log_are0.push_back(sx(oa[2*OW-1:OW], OW));
            log_bre0.push_back(sx(ob[2*OW-1:OW], OW));
            log_bim0.push_back(sx(ob[OW-1:0], OW));
            log_ovf0.push_back(longint'(ov));
        end else begin
            log_bre1.push_back(sx(ob[2*OW-1:OW], OW));
            log_bim1.push_back(sx(ob[OW-1:0], OW));
        end
    endtask

    task automatic sample();
        bit     hs, stall;
        int     kuse;
        longint are, aim, bre, bim;
        hs    = rst_n && in_valid && in_ready0;
        stall = out_valid0 && !out_ready;
        if (stalled_prev) begin
            check("stall_valid", out_valid0, 1);
            check("stall_a", longint'(out_a0), longint'(held_a));
            check("stall_b", longint'(out_b0), longint'(held_b));
            check("stall_first", out_first0, held_first);
            check("stall_ovf", ovf0, held_ovf);
        end
        if (stall) check("stall_in_ready", in_ready0, 0);
        check("frame_err0", frame_err0, longint'(hs && in_first && k_model != 0));
        check("frame_err1", frame_err1, longint'(hs && in_first && k_model != 0));
        if (out_valid0 && out_ready) check_out(0, out_first0, out_a0, out_b0, ovf0);
        if (out_valid1 && out_ready) check_out(1, out_first1, out_a1, out_b1, ovf1);
        if (hs) begin
            kuse = in_first ? 0 : k_model;
            are  = sx(in_a[2*DW-1:DW], DW);
            aim  = sx(in_a[DW-1:0], DW);
            bre  = sx(in_b[2*DW-1:DW], DW);
            bim  = sx(in_b[DW-1:0], DW);
            exp_q0.push_back(model(0, are, aim, bre, bim, kuse, in_first));
            exp_q1.push_back(model(1, are, aim, bre, bim, kuse, in_first));
            k_model = (kuse + 1) % (N / 2);
        end
        stalled_prev = stall;
        held_a       = out_a0;
        held_b       = out_b0;
        held_first   = out_first0;
        held_ovf     = ovf0;
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        drive(0, 0, 0, 0, 0, 0);
        out_ready = 1'b1;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && guard < 50) begin
            tick();
            guard++;
        end
        check("drain_left", exp_q0.size() + exp_q1.size(), 0);
    endtask

    task automatic clear_logs();
        log_are0.delete(); log_bre0.delete(); log_bim0.delete(); log_ovf0.delete();
        log_bre1.delete(); log_bim1.delete();
    endtask

    function automatic longint rnd_comp();
        case ($urandom_range(0, 7))
            0:       return (longint'(1) << (DW - 1)) - 1;
            1:       return -(longint'(1) << (DW - 1));
            default: return sx(64'($urandom), DW);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint e_bre0[4] = '{80, 57, 0, -57};
        longint e_bim0[4] = '{0, -57, -80, -57};
        longint e_bre1[4] = '{80, 0, 80, 0};
        longint e_bim1[4] = '{0, -80, 0, -80};

        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid0, 0);
        check("rst_out_a", longint'(out_a0), 0);
        check("rst_out_b", longint'(out_b0), 0);
        check("rst_frame_err", frame_err0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_out_valid1", out_valid1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", in_ready0, 1);

        // Fixed pair over one frame: twiddle walk for STAGE 0 and STAGE 1.
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            drive(1, i == 0, 100, 0, 20, 0);
            tick();
        end
        drain();
        check("dir_n", log_bre0.size(), 4);
        if (log_bre0.size() == 4 && log_bre1.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("dir_a_re[%0d]", i), log_are0[i], 120);
                check($sformatf("dir_b_re0[%0d]", i), log_bre0[i], e_bre0[i]);
                check($sformatf("dir_b_im0[%0d]", i), log_bim0[i], e_bim0[i]);
                check($sformatf("dir_b_re1[%0d]", i), log_bre1[i], e_bre1[i]);
                check($sformatf("dir_b_im1[%0d]", i), log_bim1[i], e_bim1[i]);
            end
        end

        // Misaligned frame start at k=2: pulse and W=1.
        clear_logs();
        drive(1, 1, 7, 3, 1, 1);    tick();
        drive(1, 0, -9, 4, 2, 8);   tick();
        drive(1, 1, 50, 10, 20, -5); tick();
        drive(1, 0, 11, 12, 13, 14); tick();
        drain();
        if (log_bre0.size() >= 3) begin
            check("ferr_b_re", log_bre0[2], 30);
            check("ferr_b_im", log_bim0[2], 15);
        end else check("ferr_n", log_bre0.size(), 4);

        // Overflow corner at k=1.
        clear_logs();
        drive(1, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 16777215, 16777215, -16777216, -16777216); tick();
        drain();
        if (log_bre0.size() >= 2) begin
`ifdef FFT_BF_SAT_EN
            check("ovf_b_re", log_bre0[1], 33554431);
            check("ovf_flag", log_ovf0[1], 1);
`else
            check("ovf_b_re", log_bre0[1], -19655681);
            check("ovf_flag", log_ovf0[1], 0);
`endif
            check("ovf_b_im", log_bim0[1], 0);
        end else check("ovf_n", log_bre0.size(), 2);

        // Backpressure: 5-cycle stall with continuous input.
        chk_lat = 1'b0;
        for (int i = 0; i < 14; i++) begin
            drive(1, i == 0, rnd_comp(), rnd_comp(), rnd_comp(), rnd_comp());
            out_ready = !(i >= 4 && i < 9);
            tick();
        end
        drain();

        // Reset with two beats in flight.
        chk_lat = 1'b1;
        drive(1, 1, 5, 6, 7, 8);   tick();
        drive(1, 0, 9, 10, 11, 12); tick();
        drive(0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid0", out_valid0, 0);
        check("midrst_valid1", out_valid1, 0);
        check("midrst_out_b", longint'(out_b0), 0);
        exp_q0.delete();
        exp_q1.delete();
        k_model      = 0;
        stalled_prev = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready", in_ready0, 1);
        repeat (5) tick();
        clear_logs();
        drive(1, 0, 100, 0, 20, 0); tick();
        drain();
        if (log_bre0.size() >= 1) begin
            check("midrst_k0_b_re", log_bre0[0], 80);
            check("midrst_k0_b_im", log_bim0[0], 0);
        end else check("midrst_n", log_bre0.size(), 1);

        // Randomised traffic with random backpressure and frame marks.
        chk_lat = 1'b0;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  rnd_comp(), rnd_comp(), rnd_comp(), rnd_comp());
            out_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
